// File: rtl/bmp_header_parser_pkg.sv
// Shared constants, state/field encodings and small decode helpers for the
// BMP header parser.
package bmp_header_parser_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int ADDR_WIDTH = 20;
  localparam int HDR_BYTES  = 54;
  localparam logic [31:0] BMP_TOTAL_SIZE = 32'd786486;

  localparam logic [ADDR_WIDTH-1:0] OFS_SIG    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFS_OFFSET = ADDR_WIDTH'(10);
  localparam logic [ADDR_WIDTH-1:0] OFS_WIDTH  = ADDR_WIDTH'(18);
  localparam logic [ADDR_WIDTH-1:0] OFS_HEIGHT = ADDR_WIDTH'(22);
  localparam logic [ADDR_WIDTH-1:0] OFS_PLANES = ADDR_WIDTH'(26);
  localparam logic [ADDR_WIDTH-1:0] OFS_BPP    = ADDR_WIDTH'(28);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    FLD_NONE   = 3'd0,
    FLD_SIG    = 3'd1,
    FLD_OFFSET = 3'd2,
    FLD_WIDTH  = 3'd3,
    FLD_HEIGHT = 3'd4,
    FLD_PLANES = 3'd5,
    FLD_BPP    = 3'd6
  } fld_e;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx,
                                    input logic [ADDR_WIDTH-1:0] base,
                                    input logic [ADDR_WIDTH-1:0] len);
    return (idx >= base) && (idx < (base + len));
  endfunction

  function automatic fld_e field_of(input logic [ADDR_WIDTH-1:0] idx);
    fld_e f;
    f = FLD_NONE;
    if (in_range(idx, OFS_SIG, ADDR_WIDTH'(2)))         f = FLD_SIG;
    else if (in_range(idx, OFS_OFFSET, ADDR_WIDTH'(4))) f = FLD_OFFSET;
    else if (in_range(idx, OFS_WIDTH, ADDR_WIDTH'(4)))  f = FLD_WIDTH;
    else if (in_range(idx, OFS_HEIGHT, ADDR_WIDTH'(4))) f = FLD_HEIGHT;
    else if (in_range(idx, OFS_PLANES, ADDR_WIDTH'(2))) f = FLD_PLANES;
    else if (in_range(idx, OFS_BPP, ADDR_WIDTH'(2)))    f = FLD_BPP;
    else                                                f = FLD_NONE;
    return f;
  endfunction

  // Lane within a field only needs the low two address bits (fields are <= 4 bytes).
  function automatic logic [1:0] field_lane(input logic [ADDR_WIDTH-1:0] idx,
                                            input fld_e fld);
    logic [1:0] base;
    case (fld)
      FLD_OFFSET: base = OFS_OFFSET[1:0];
      FLD_WIDTH:  base = OFS_WIDTH[1:0];
      FLD_HEIGHT: base = OFS_HEIGHT[1:0];
      FLD_PLANES: base = OFS_PLANES[1:0];
      FLD_BPP:    base = OFS_BPP[1:0];
      default:    base = OFS_SIG[1:0];
    endcase
    return idx[1:0] - base;
  endfunction

endpackage

// File: rtl/bmp_field_capture.sv
// Assembles the little-endian BMP header fields from a stream of
// (byte index, byte, strobe) updates.
module bmp_field_capture
  import bmp_header_parser_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  strobe,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [BYTE_WIDTH-1:0] data,
  output logic [15:0]           sig,
  output logic [15:0]           planes,
  output logic [15:0]           bpp,
  output logic [31:0]           pixel_offset,
  output logic [31:0]           img_width,
  output logic [31:0]           img_height
);

  logic [15:0] sig_q, sig_d, planes_q, planes_d, bpp_q, bpp_d;
  logic [31:0] offset_q, offset_d, width_q, width_d, height_q, height_d;
  fld_e        fld_s;
  logic [1:0]  lane_s;

  // Route the strobed byte into its lane of the owning field register.
  always_comb begin
    sig_d    = sig_q;
    planes_d = planes_q;
    bpp_d    = bpp_q;
    offset_d = offset_q;
    width_d  = width_q;
    height_d = height_q;
    fld_s    = strobe ? field_of(idx) : FLD_NONE;
    lane_s   = field_lane(idx, fld_s);
    case (fld_s)
      FLD_SIG:    sig_d[{lane_s[0], 3'b000} +: BYTE_WIDTH]    = data;
      FLD_PLANES: planes_d[{lane_s[0], 3'b000} +: BYTE_WIDTH] = data;
      FLD_BPP:    bpp_d[{lane_s[0], 3'b000} +: BYTE_WIDTH]    = data;
      FLD_OFFSET: offset_d[{lane_s, 3'b000} +: BYTE_WIDTH]    = data;
      FLD_WIDTH:  width_d[{lane_s, 3'b000} +: BYTE_WIDTH]     = data;
      FLD_HEIGHT: height_d[{lane_s, 3'b000} +: BYTE_WIDTH]    = data;
      default: begin
      end
    endcase
  end

  // Field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q    <= 16'd0;
      planes_q <= 16'd0;
      bpp_q    <= 16'd0;
      offset_q <= 32'd0;
      width_q  <= 32'd0;
      height_q <= 32'd0;
    end else begin
      sig_q    <= sig_d;
      planes_q <= planes_d;
      bpp_q    <= bpp_d;
      offset_q <= offset_d;
      width_q  <= width_d;
      height_q <= height_d;
    end
  end

  assign sig          = sig_q;
  assign planes       = planes_q;
  assign bpp          = bpp_q;
  assign pixel_offset = offset_q;
  assign img_width    = width_q;
  assign img_height   = height_q;

endmodule

// File: rtl/bmp_header_parser.sv
// Streams the 54-byte BMP header from ROM, copies it to RAM at the same
// addresses, decodes the key fields and flags headers the pipeline cannot use.
module bmp_header_parser
  import bmp_header_parser_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] ROM_out,
  output logic                  ROM_valid,
  output logic [ADDR_WIDTH-1:0] ROM_addr,
  output logic                  RAM_wen,
  output logic [BYTE_WIDTH-1:0] RAM_in,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic [31:0]           pixel_offset,
  output logic [31:0]           img_width,
  output logic [31:0]           img_height,
  output logic                  hdr_done,
  output logic                  hdr_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(HDR_BYTES - 1);

  state_e                state_q, state_d;
  logic                  rom_valid_q, rom_valid_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                  ram_wen_q, ram_wen_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [BYTE_WIDTH-1:0] ram_in_q, ram_in_d;
  logic                  hdr_done_q, hdr_done_d;
  logic                  hdr_err_q, hdr_err_d;

  logic [15:0] sig_s, planes_s, bpp_s;
  logic [63:0] area_s;
  logic [65:0] total_s;
  logic        err_s;

  bmp_field_capture u_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .strobe       (rd_pend_q),
    .idx          (rd_idx_q),
    .data         (ROM_out),
    .sig          (sig_s),
    .planes       (planes_s),
    .bpp          (bpp_s),
    .pixel_offset (pixel_offset),
    .img_width    (img_width),
    .img_height   (img_height)
  );

  // Header validity; the extra two bits keep the *3 and offset add from wrapping.
  always_comb begin
    area_s  = {32'd0, img_width} * {32'd0, img_height};
    total_s = ({2'b00, area_s} * 66'd3) + {34'd0, pixel_offset};
    err_s   = (sig_s != 16'h4D42) || (planes_s != 16'd1) || (bpp_s != 16'd24) ||
              (img_width == 32'd0) || (img_height == 32'd0) || img_height[31] ||
              (pixel_offset < 32'(HDR_BYTES)) ||
              (total_s > {34'd0, BMP_TOTAL_SIZE});
  end

  // Sequencer: issue the reads, wait for the copy to land, then judge once.
  always_comb begin
    state_d     = state_q;
    rom_valid_d = 1'b0;
    rom_addr_d  = rom_addr_q;
    hdr_done_d  = hdr_done_q;
    hdr_err_d   = hdr_err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d     = ST_READ;
          rom_valid_d = 1'b1;
          rom_addr_d  = ADDR_WIDTH'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
        end else begin
          rom_valid_d = 1'b1;
          rom_addr_d  = rom_addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (!rd_pend_q && !ram_wen_q) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_CHECK: begin
        state_d    = ST_DONE;
        hdr_done_d = 1'b1;
        hdr_err_d  = err_s;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-return tracking and the single registered write stage.
  always_comb begin
    rd_pend_d  = rom_valid_q;
    rd_idx_d   = rom_addr_q;
    ram_wen_d  = rd_pend_q;
    ram_addr_d = rd_pend_q ? rd_idx_q : ram_addr_q;
    ram_in_d   = rd_pend_q ? ROM_out : ram_in_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rom_valid_q <= 1'b0;
      rom_addr_q  <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_in_q    <= '0;
      hdr_done_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_valid_q <= rom_valid_d;
      rom_addr_q  <= rom_addr_d;
      rd_pend_q   <= rd_pend_d;
      rd_idx_q    <= rd_idx_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_in_q    <= ram_in_d;
      hdr_done_q  <= hdr_done_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

  assign ROM_valid = rom_valid_q;
  assign ROM_addr  = rom_addr_q;
  assign RAM_wen   = ram_wen_q;
  assign RAM_addr  = ram_addr_q;
  assign RAM_in    = ram_in_q;
  assign hdr_done  = hdr_done_q;
  assign hdr_err   = hdr_err_q;

endmodule

// File: tb/tb_bmp_header_parser.sv
// Directed self-checking bench for bmp_header_parser with a synchronous ROM model.
module tb_bmp_header_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  ROM_out;
  logic        ROM_valid;
  logic [19:0] ROM_addr;
  logic        RAM_wen;
  logic [7:0]  RAM_in;
  logic [19:0] RAM_addr;
  logic [31:0] pixel_offset, img_width, img_height;
  logic        hdr_done, hdr_err;

  logic [7:0]  rom [0:63];
  int vectors = 0;
  int miscompares = 0;

  bmp_header_parser dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ROM_out(ROM_out),
    .ROM_valid(ROM_valid), .ROM_addr(ROM_addr), .RAM_wen(RAM_wen),
    .RAM_in(RAM_in), .RAM_addr(RAM_addr), .pixel_offset(pixel_offset),
    .img_width(img_width), .img_height(img_height),
    .hdr_done(hdr_done), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ROM_valid) ROM_out <= rom[ROM_addr[5:0]];
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_valid_rom();
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[0] = 8'h42; rom[1] = 8'h4D;
    rom[2] = 8'h36; rom[3] = 8'h00; rom[4] = 8'h0C; rom[5] = 8'h00;
    rom[10] = 8'h36;
    rom[14] = 8'h28;
    rom[18] = 8'h00; rom[19] = 8'h02;
    rom[22] = 8'h00; rom[23] = 8'h02;
    rom[26] = 8'h01;
    rom[28] = 8'h18;
    rom[36] = 8'h0C;
    for (int i = 38; i < 54; i++) rom[i] = 8'(i) ^ 8'hA5;
  endtask

  // Starts a parse and observes it; posedge n is the n-th edge after the start edge.
  task automatic run_parse(output int done_n, output int rd_n, output int wr_n,
                           output int first_n, output int last_n, output int bad_n);
    int n;
    done_n = -1; rd_n = 0; wr_n = 0; first_n = -1; last_n = -1; bad_n = 0; n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (n <= 200) begin
      if (ROM_valid) begin
        if (ROM_addr !== 20'(rd_n)) bad_n++;
        rd_n++;
      end
      if (RAM_wen) begin
        if (wr_n == 0) first_n = n;
        last_n = n;
        if (wr_n > 63) bad_n++;
        else if (RAM_addr !== 20'(wr_n) || RAM_in !== rom[wr_n]) bad_n++;
        wr_n++;
      end
      if (hdr_done) begin
        done_n = n;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_run(input string name, input logic exp_err);
    int done_n, rd_n, wr_n, first_n, last_n, bad_n;
    run_parse(done_n, rd_n, wr_n, first_n, last_n, bad_n);
    vectors++;
    if (done_n !== 58) begin
      miscompares++;
      $display("FAIL %s latency: got %0d, expected 58", name, done_n);
    end
    vectors++;
    if (hdr_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s hdr_err: got %b, expected %b", name, hdr_err, exp_err);
    end
    vectors++;
    if (rd_n !== 54 || wr_n !== 54 || bad_n !== 0) begin
      miscompares++;
      $display("FAIL %s copy: reads %0d writes %0d bad %0d, expected 54 54 0",
               name, rd_n, wr_n, bad_n);
    end
    vectors++;
    if (first_n !== 2 || last_n !== 55) begin
      miscompares++;
      $display("FAIL %s write window: wen after posedges %0d..%0d, expected 2..55",
               name, first_n, last_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ROM_valid, ROM_addr, RAM_wen, RAM_addr, RAM_in, hdr_done, hdr_err} !== 52'd0 ||
        {pixel_offset, img_width, img_height} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset outputs: some output nonzero (rom_valid=%b wen=%b done=%b)",
               ROM_valid, RAM_wen, hdr_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_valid_header();
    int anomalies;
    do_reset();
    load_valid_rom();
    check_run("valid", 1'b0);
    vectors++;
    if (pixel_offset !== 32'd54 || img_width !== 32'd512 || img_height !== 32'd512) begin
      miscompares++;
      $display("FAIL valid fields: offset %0d width %0d height %0d, expected 54 512 512",
               pixel_offset, img_width, img_height);
    end
    anomalies = 0;
    @(negedge clk);
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ROM_valid || RAM_wen || !hdr_done || hdr_err || pixel_offset !== 32'd54) anomalies++;
    end
    in_valid = 1'b0;
    vectors++;
    if (anomalies !== 0) begin
      miscompares++;
      $display("FAIL done_hold: %0d unstable cycles, expected 0", anomalies);
    end
  endtask

  task automatic test_bad_signature();
    do_reset();
    load_valid_rom();
    rom[1] = 8'h41;
    check_run("bad_sig", 1'b1);
  endtask

  task automatic test_bad_bpp();
    do_reset();
    load_valid_rom();
    rom[28] = 8'h08;
    check_run("bad_bpp", 1'b1);
  endtask

  task automatic test_negative_height();
    do_reset();
    load_valid_rom();
    rom[22] = 8'h00; rom[23] = 8'hFE; rom[24] = 8'hFF; rom[25] = 8'hFF;
    check_run("neg_height", 1'b1);
    vectors++;
    if (img_height !== 32'hFFFF_FE00) begin
      miscompares++;
      $display("FAIL neg_height field: got %h, expected fffffe00", img_height);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    load_valid_rom();
    rom[19] = 8'h04;
    rom[23] = 8'h04;
    check_run("oversize", 1'b1);
    vectors++;
    if (img_width !== 32'd1024 || img_height !== 32'd1024) begin
      miscompares++;
      $display("FAIL oversize fields: %0d x %0d, expected 1024 x 1024", img_width, img_height);
    end
  endtask

  task automatic test_offset_bounds();
    do_reset();
    load_valid_rom();
    rom[10] = 8'h28;
    check_run("offset40", 1'b1);
    vectors++;
    if (pixel_offset !== 32'd40) begin
      miscompares++;
      $display("FAIL offset40 field: got %0d, expected 40", pixel_offset);
    end
    do_reset();
    load_valid_rom();
    rom[10] = 8'h37;
    check_run("offset55", 1'b1);
  endtask

  task automatic test_idle();
    int seen;
    do_reset();
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (ROM_valid || RAM_wen || hdr_done) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL idle: %0d active cycles, expected 0", seen);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    load_valid_rom();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ROM_valid, ROM_addr, RAM_wen, RAM_addr, RAM_in, hdr_done, hdr_err} !== 52'd0 ||
        {pixel_offset, img_width, img_height} !== 96'd0) begin
      miscompares++;
      $display("FAIL mid_reset outputs: rom_valid=%b rom_addr=%0d offset=%0d, expected all 0",
               ROM_valid, ROM_addr, pixel_offset);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_run("restart", 1'b0);
    vectors++;
    if (pixel_offset !== 32'd54 || img_width !== 32'd512 || img_height !== 32'd512) begin
      miscompares++;
      $display("FAIL restart fields: offset %0d width %0d height %0d, expected 54 512 512",
               pixel_offset, img_width, img_height);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    test_reset();
    test_valid_header();
    test_bad_signature();
    test_bad_bpp();
    test_negative_height();
    test_oversize();
    test_offset_bounds();
    test_idle();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bmp_header_parser.md
Name: bmp_header_parser

Overview:
Front stage of the image pipeline. It sits between BMP_ROM and BGR2GRAY.
- Streams the 54-byte BMP file header out of the ROM.
- Copies each byte unchanged into the dual-port RAM at the same address, so the output image keeps a valid header.
- Decodes the little-endian header fields and checks them.
- Raises hdr_done to release BGR2GRAY, or raises hdr_err if the image cannot be processed.

Parameters:
BYTE_WIDTH, 8, width of a ROM/RAM data byte
ADDR_WIDTH, 20, width of ROM/RAM byte address
HDR_BYTES, 54, number of header bytes parsed and copied
BMP_TOTAL_SIZE, 786486, file size in bytes (512x512x3 + 54); upper bound for the pixel offset check

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  start request; level, sampled in IDLE
ROM_out  input  BYTE_WIDTH  ROM read data; valid one cycle after the address is presented with ROM_valid=1
ROM_valid  output  1  ROM read enable
ROM_addr  output  ADDR_WIDTH  ROM byte address
RAM_wen  output  1  RAM port-1 write enable
RAM_in  output  BYTE_WIDTH  RAM write data
RAM_addr  output  ADDR_WIDTH  RAM write address
pixel_offset  output  32  header bytes 10..13
img_width  output  32  header bytes 18..21
img_height  output  32  header bytes 22..25
hdr_done  output  1  level; parse finished, held until reset
hdr_err  output  1  level; header rejected, valid when hdr_done=1

Behaviour:
- Clock and reset: single clock clk. Asynchronous active-low reset rst_n.
- Reset values: all outputs 0; state IDLE; internal address counter 0.
- State machine: IDLE -> READ -> DRAIN -> CHECK -> DONE. DONE is terminal until reset.
- IDLE: ROM_valid=0. in_valid=1 at a posedge moves to READ.
- READ: ROM_valid=1, ROM_addr=cnt, cnt increments every cycle from 0 to HDR_BYTES-1. After issuing HDR_BYTES-1, go to DRAIN.
- Data/write pipeline:
  - One registered stage: the byte returned for address a is written with RAM_wen=1, RAM_addr=a, RAM_in=byte in the cycle after it arrives.
  - RAM writes therefore occupy addresses 0..53 contiguously with no gaps.
- DRAIN: ROM_valid=0; wait until the last RAM write has completed (2 cycles), then go to CHECK.
- Field capture:
  - Each returned byte at index i is loaded into byte lane (i - base) of its field register.
  - Signature is bytes 0..1, planes bytes 26..27, bpp bytes 28..29; these three are internal.
  - pixel_offset, img_width and img_height are visible on their ports as they fill.
- CHECK, one cycle. hdr_err is set if any of the following holds:
  - signature != 16'h4D42 (byte 0 = 'B', byte 1 = 'M')
  - planes != 1
  - bpp != 24
  - img_width == 0
  - img_height == 0 or img_height[31] == 1 (top-down images are rejected)
  - pixel_offset < HDR_BYTES
  - pixel_offset + width*height*3 > BMP_TOTAL_SIZE, compared as a 64-bit unsigned product
- DONE: hdr_done=1, and hdr_err keeps the CHECK result. All outputs hold steady; in_valid is ignored.
- Latency: with in_valid first seen at posedge 0, the ROM addresses 0..53 are issued at posedges 1..54.
  - RAM writes at posedges 3..56.
  - CHECK at posedge 57.
  - hdr_done=1 visible after posedge 58.
  - Total 58 cycles, fixed and independent of the header content.
- Errors do not abort the copy: all 54 bytes are always written to RAM.
- Reset mid-operation: every output returns to 0 immediately. Partially written RAM contents are left as they are. A new in_valid restarts from address 0.
- in_valid dropping after the start has no effect.

Decomposition:
- Shared constants go in DEFINE.vh: BYTE_WIDTH, ADDR_WIDTH, HDR_BYTES, and the field byte offsets (SIG=0, OFFSET=10, WIDTH=18, HEIGHT=22, PLANES=26, BPP=28), plus the state encodings.
- One sub-module: bmp_field_capture. It takes (byte index, byte, strobe) and returns the little-endian assembled 32-bit fields. It is instanced once.

Test Plan:
- Valid 512x512 24-bpp header, offset 54 -> pixel_offset=54, img_width=512, img_height=512, hdr_err=0, hdr_done=1 58 cycles after start; RAM[0..53] equals ROM[0..53].
- Byte 1 = 8'h41 ("BA") -> hdr_done=1 at cycle 58, hdr_err=1, all 54 bytes still copied.
- bpp=8 (byte 28 = 8'h08) -> hdr_err=1. Separately, height bytes FF FF FE 00 (img_height=32'h00FEFFFF? no: bytes 22..25 = 00 FE FF FF, i.e. -512) -> hdr_err=1.
- Header claiming 1024x1024 with BMP_TOTAL_SIZE=786486 -> hdr_err=1. pixel_offset=40 -> hdr_err=1.
- in_valid held 0 for 100 cycles -> ROM_valid, RAM_wen and hdr_done stay 0.
- rst_n pulsed low at cycle 20 of READ -> all outputs 0 asynchronously; restart with in_valid -> identical results to the first scenario, hdr_done 58 cycles after the restart.
